// File: rtl/c3demo_bus_pkg.sv
// Shared definitions for the picorv32-style native memory bus fabric.
package c3demo_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  // Read data handed back to a master whose transaction was killed by the watchdog
  localparam logic [DATA_W-1:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  // Arbiter state encoding
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/mem_bus_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the search starts at the requester just after
// the previous winner, so every requester is served within N grants.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] last_grant,
  output logic [N-1:0] winner
);

  int   lg_idx;
  int   idx;
  logic found;

  // Locate the previous winner, then scan forward (wrapping) for the first requester
  always_comb begin
    lg_idx = 0;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < N; i++) begin
      if (last_grant[i]) begin
        lg_idx = i;
      end
    end
    for (int off = 1; off <= N; off++) begin
      idx = (lg_idx + off) % N;
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one native memory port between N masters with round-robin arbitration,
// a single outstanding transaction, and a watchdog that terminates transactions
// the slave never answers.
module mem_bus_arbiter
  import c3demo_bus_pkg::*;
#(
  parameter int                N_MASTERS      = 2,
  parameter int                TIMEOUT_CYCLES = 64,
  parameter logic [DATA_W-1:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_MASTERS-1:0]        m_valid,
  input  logic [ADDR_W*N_MASTERS-1:0] m_addr,
  input  logic [DATA_W*N_MASTERS-1:0] m_wdata,
  input  logic [STRB_W*N_MASTERS-1:0] m_wstrb,
  output logic [N_MASTERS-1:0]        m_ready,
  output logic [DATA_W-1:0]           m_rdata,
  output logic                        s_valid,
  output logic [ADDR_W-1:0]           s_addr,
  output logic [DATA_W-1:0]           s_wdata,
  output logic [STRB_W-1:0]           s_wstrb,
  input  logic                        s_ready,
  input  logic [DATA_W-1:0]           s_rdata,
  output logic [N_MASTERS-1:0]        grant,
  output logic                        busy,
  output logic                        err_sticky,
  output logic [ADDR_W-1:0]           err_addr,
  input  logic                        err_clear
);

  // The watchdog fires in the BUSY cycle whose count equals this limit
  localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT_CYCLES - 1);

  // Resetting the history to the highest index makes master 0 win first
  localparam logic [N_MASTERS-1:0] LAST_INIT = {1'b1, {(N_MASTERS-1){1'b0}}};

  state_t               state;
  logic [N_MASTERS-1:0] last_grant;
  logic [N_MASTERS-1:0] rr_winner;
  logic [7:0]           wd_count;
  logic                 slave_done;
  logic                 wd_expire;

  rr_arbiter #(
    .N (N_MASTERS)
  ) u_rr (
    .req        (m_valid),
    .last_grant (last_grant),
    .winner     (rr_winner)
  );

  assign busy    = (state == ST_BUSY);
  assign s_valid = busy;

  // A slave answer always beats the watchdog; reset suppresses any completion
  assign slave_done = busy && s_ready && !reset;
  assign wd_expire  = busy && !s_ready && (wd_count == WD_LIMIT) && !reset;

  // Completion pulse to the owner and broadcast read data, zero otherwise
  always_comb begin
    m_ready = '0;
    m_rdata = '0;
    if (slave_done) begin
      m_ready = grant;
      m_rdata = s_rdata;
    end else if (wd_expire) begin
      m_ready = grant;
      m_rdata = ERR_RDATA;
    end
  end

  // Forward the owner's request fields live; zero while idle since grant is 0
  always_comb begin
    s_addr  = '0;
    s_wdata = '0;
    s_wstrb = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (grant[i]) begin
        s_addr  = m_addr[ADDR_W*i +: ADDR_W];
        s_wdata = m_wdata[DATA_W*i +: DATA_W];
        s_wstrb = m_wstrb[STRB_W*i +: STRB_W];
      end
    end
  end

  // IDLE/BUSY controller with registered grant, arbitration history and watchdog count
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last_grant <= LAST_INIT;
      wd_count   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|m_valid) begin
            grant      <= rr_winner;
            last_grant <= rr_winner;
            wd_count   <= '0;
            state      <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (s_ready || (wd_count == WD_LIMIT)) begin
            grant    <= '0;
            wd_count <= '0;
            state    <= ST_IDLE;
          end else begin
            wd_count <= wd_count + 8'd1;
          end
        end
        default: begin
          grant    <= '0;
          wd_count <= '0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky error flag; a timeout in the same cycle as a clear still sets it and re-captures
  always_ff @(posedge clk) begin
    if (reset) begin
      err_sticky <= 1'b0;
      err_addr   <= '0;
    end else if (wd_expire) begin
      err_sticky <= 1'b1;
      if (!err_sticky || err_clear) begin
        err_addr <= s_addr;
      end
    end else if (err_clear) begin
      err_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: a transaction-level model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_mem_bus_arbiter;

  localparam int          N    = 2;
  localparam int          T    = 16;
  localparam logic [31:0] ERRW = 32'hDEAD_BEEF;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    m_valid;
  logic [32*N-1:0] m_addr;
  logic [32*N-1:0] m_wdata;
  logic [4*N-1:0]  m_wstrb;
  logic [N-1:0]    m_ready;
  logic [31:0]     m_rdata;
  logic            s_valid;
  logic [31:0]     s_addr;
  logic [31:0]     s_wdata;
  logic [3:0]      s_wstrb;
  logic            s_ready;
  logic [31:0]     s_rdata;
  logic [N-1:0]    grant;
  logic            busy;
  logic            err_sticky;
  logic [31:0]     err_addr;
  logic            err_clear;

  int errors = 0;
  int checks = 0;

  // Model state: owner index (-1 when idle), 1-based BUSY cycle, previous winner, error flag/address
  int          owner   = -1;
  int          bcyc    = 0;
  int          last    = N - 1;
  logic        esticky = 1'b0;
  logic [31:0] eaddr   = 32'h0;
  logic        model_on = 1'b0;

  mem_bus_arbiter #(
    .N_MASTERS      (N),
    .TIMEOUT_CYCLES (T),
    .ERR_RDATA      (ERRW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .m_valid    (m_valid),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_wstrb    (m_wstrb),
    .m_ready    (m_ready),
    .m_rdata    (m_rdata),
    .s_valid    (s_valid),
    .s_addr     (s_addr),
    .s_wdata    (s_wdata),
    .s_wstrb    (s_wstrb),
    .s_ready    (s_ready),
    .s_rdata    (s_rdata),
    .grant      (grant),
    .busy       (busy),
    .err_sticky (err_sticky),
    .err_addr   (err_addr),
    .err_clear  (err_clear)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic v, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] s);
    m_valid[idx]        = v;
    m_addr[32*idx +: 32] = a;
    m_wdata[32*idx +: 32] = d;
    m_wstrb[4*idx +: 4]  = s;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    step();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Model check and advance: inputs only change just after posedge, so they are stable here
  always @(negedge clk) begin
    logic         done;
    logic         to;
    logic [N-1:0] exp_ready;
    logic [31:0]  exp_rdata;
    int           c;
    if (model_on) begin
      done      = (owner >= 0) && s_ready && !reset;
      to        = (owner >= 0) && !s_ready && (bcyc == T) && !reset;
      exp_ready = (done || to) ? (N'(1) << owner) : '0;
      exp_rdata = done ? s_rdata : (to ? ERRW : 32'h0);
      checkOutput("busy", 32'(busy), 32'(owner >= 0));
      checkOutput("s_valid", 32'(s_valid), 32'(owner >= 0));
      checkOutput("grant", 32'(grant), (owner >= 0) ? (32'(1) << owner) : 32'(0));
      checkOutput("m_ready", 32'(m_ready), 32'(exp_ready));
      checkOutput("m_rdata", m_rdata, exp_rdata);
      checkOutput("err_sticky", 32'(err_sticky), 32'(esticky));
      checkOutput("err_addr", err_addr, eaddr);
      checkOutput("ready_onehot", 32'($countones(m_ready) <= 1), 32'(1));
      if (owner >= 0) begin
        checkOutput("s_addr", s_addr, m_addr[32*owner +: 32]);
        checkOutput("s_wdata", s_wdata, m_wdata[32*owner +: 32]);
        checkOutput("s_wstrb", 32'(s_wstrb), 32'(m_wstrb[4*owner +: 4]));
      end
      if (reset) begin
        owner   = -1;
        bcyc    = 0;
        last    = N - 1;
        esticky = 1'b0;
        eaddr   = 32'h0;
      end else begin
        if (to) begin
          if (!esticky || err_clear) eaddr = m_addr[32*owner +: 32];
          esticky = 1'b1;
        end else if (err_clear) begin
          esticky = 1'b0;
        end
        if (owner < 0) begin
          for (int k = 1; k <= N; k++) begin
            c = (last + k) % N;
            if (m_valid[c]) begin
              owner = c;
              last  = c;
              bcyc  = 1;
              break;
            end
          end
        end else if (done || to) begin
          owner = -1;
        end else begin
          bcyc++;
        end
      end
    end
  end

  // Directed scenarios with hand-computed expectations
  initial begin
    int got;
    int bc;
    int found;
    int ord[6];
    int exp_ord[6];
    exp_ord = '{1, 2, 1, 2, 1, 2};
    m_valid = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    s_ready = 1'b0; s_rdata = 32'h0; err_clear = 1'b0; reset = 1'b1;
    @(posedge clk);
    #1;
    model_on = 1'b1;
    @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_grant", 32'(grant), 32'h0);
    checkOutput("rst_err_sticky", 32'(err_sticky), 32'h0);
    checkOutput("rst_err_addr", err_addr, 32'h0);
    step();
    reset = 1'b0;

    $display("[TB] test 1: single read");
    applyStimulus(0, 1'b1, 32'h0000_0100, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("t1_s_valid_before", 32'(s_valid), 32'h0);
    step();
    @(negedge clk);
    checkOutput("t1_s_valid", 32'(s_valid), 32'h1);
    checkOutput("t1_s_addr", s_addr, 32'h0000_0100);
    checkOutput("t1_no_ready", 32'(m_ready), 32'h0);
    step();
    s_ready = 1'b1; s_rdata = 32'h1234_5678;
    @(negedge clk);
    checkOutput("t1_m_ready", 32'(m_ready), 32'h1);
    checkOutput("t1_m_rdata", m_rdata, 32'h1234_5678);
    step();
    s_ready = 1'b0; s_rdata = 32'h0;
    applyStimulus(0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("t1_s_valid_drop", 32'(s_valid), 32'h0);

    $display("[TB] test 2: round-robin rotation");
    doReset();
    applyStimulus(0, 1'b1, 32'h0000_0200, 32'h0, 4'h0);
    applyStimulus(1, 1'b1, 32'h0000_0204, 32'h0, 4'h0);
    s_ready = 1'b1; s_rdata = 32'h0BAD_0000;
    got = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (m_ready != '0) begin
        ord[got] = int'(grant);
        got++;
      end
      if (got == 6) break;
      step();
      s_rdata = s_rdata + 32'h1;
    end
    checkOutput("t2_count", 32'(got), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < got) checkOutput($sformatf("t2_grant%0d", i), 32'(ord[i]), 32'(exp_ord[i]));
    end
    step();
    m_valid = '0; s_ready = 1'b0; s_rdata = 32'h0;

    $display("[TB] test 3: write from master 1");
    applyStimulus(1, 1'b1, 32'h1000_0040, 32'h00FF_00FF, 4'b0101);
    step();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("t3_s_valid", 32'(s_valid), 32'h1);
      checkOutput("t3_grant", 32'(grant), 32'h2);
      checkOutput("t3_s_addr", s_addr, 32'h1000_0040);
      checkOutput("t3_s_wdata", s_wdata, 32'h00FF_00FF);
      checkOutput("t3_s_wstrb", 32'(s_wstrb), 32'h5);
      step();
    end
    s_ready = 1'b1; s_rdata = 32'h0;
    @(negedge clk);
    checkOutput("t3_m_ready", 32'(m_ready), 32'h2);
    checkOutput("t3_m_rdata", m_rdata, 32'h0);
    step();
    s_ready = 1'b0;
    applyStimulus(1, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("t3_single_pulse", 32'(m_ready), 32'h0);

    $display("[TB] test 4: watchdog timeout");
    step();
    applyStimulus(0, 1'b1, 32'h3000_0000, 32'h0, 4'h0);
    bc = 0; found = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (busy) bc++;
      if (m_ready != '0) begin
        found = 1;
        break;
      end
      step();
    end
    checkOutput("t4_found", 32'(found), 32'h1);
    checkOutput("t4_busy_cycles", 32'(bc), 32'd16);
    checkOutput("t4_m_ready", 32'(m_ready), 32'h1);
    checkOutput("t4_m_rdata", m_rdata, 32'hDEAD_BEEF);
    step();
    applyStimulus(0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("t4_err_sticky", 32'(err_sticky), 32'h1);
    checkOutput("t4_err_addr", err_addr, 32'h3000_0000);
    checkOutput("t4_idle", 32'(busy), 32'h0);
    step();
    s_ready = 1'b1; s_rdata = 32'h1111_1111;
    @(negedge clk);
    checkOutput("t4_late_ready", 32'(m_ready), 32'h0);
    checkOutput("t4_late_rdata", m_rdata, 32'h0);
    step();
    s_ready = 1'b0; s_rdata = 32'h0; err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    @(negedge clk);
    checkOutput("t4_cleared", 32'(err_sticky), 32'h0);

    $display("[TB] test 5: slave answer at watchdog limit");
    step();
    applyStimulus(0, 1'b1, 32'h3000_0004, 32'h0, 4'h0);
    step();
    repeat (15) step();
    s_ready = 1'b1; s_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    checkOutput("t5_m_ready", 32'(m_ready), 32'h1);
    checkOutput("t5_m_rdata", m_rdata, 32'hCAFE_F00D);
    step();
    s_ready = 1'b0; s_rdata = 32'h0;
    applyStimulus(0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("t5_no_error", 32'(err_sticky), 32'h0);
    checkOutput("t5_idle", 32'(busy), 32'h0);

    $display("[TB] test 6: reset mid-transaction");
    step();
    applyStimulus(1, 1'b1, 32'h2000_0008, 32'h0, 4'h0);
    step();
    step();
    step();
    reset = 1'b1;
    @(negedge clk);
    checkOutput("t6_busy_before", 32'(busy), 32'h1);
    checkOutput("t6_no_ready_in_reset", 32'(m_ready), 32'h0);
    step();
    @(negedge clk);
    checkOutput("t6_busy", 32'(busy), 32'h0);
    checkOutput("t6_grant", 32'(grant), 32'h0);
    checkOutput("t6_s_valid", 32'(s_valid), 32'h0);
    checkOutput("t6_m_ready", 32'(m_ready), 32'h0);
    step();
    reset = 1'b0;
    applyStimulus(0, 1'b1, 32'h2000_0010, 32'h0, 4'h0);
    step();
    @(negedge clk);
    checkOutput("t6_first_grant", 32'(grant), 32'h1);
    checkOutput("t6_busy_again", 32'(busy), 32'h1);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so the run can never hang
  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "[TB] aborted");
  end

endmodule
